// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - configures uart_top, reads received bytes into a FIFO stream
// Optional saturating error-frame counter enabled by UART_RX_CTRL_ERR_CNT_EN.
module uart_rx_ctrl #(
  parameter logic [4:0] ADDR_CTRL    = 5'h00,
  parameter logic [4:0] ADDR_RX_DATA = 5'h03,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [15:0] baud_div_i,
  output logic        cfg_we_o,
  output logic        cfg_cs_o,
  output logic [4:0]  cfg_addr_o,
  output logic [31:0] cfg_wdata_o,
  input  logic [31:0] cfg_rdata_i,
  input  logic        rx_int_i,
  input  logic        err_int_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        ovf_o,
  output logic [7:0]  err_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_WAIT,
    S_RD1,
    S_RD2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_err_tag;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_ovf;

  logic        w_empty;
  logic        w_full;
  logic        w_rd_done;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic        w_unused_rdata;

  assign w_unused_rdata = ^cfg_rdata_i[31:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    cfg_cs_o    = 1'b0;
    cfg_we_o    = 1'b0;
    cfg_addr_o  = 5'h00;
    cfg_wdata_o = 32'h0000_0000;
    case (r_state)
      S_IDLE: begin
        if (enable_i) w_next = S_CFG;
      end
      S_CFG: begin
        cfg_cs_o    = 1'b1;
        cfg_we_o    = 1'b1;
        cfg_addr_o  = ADDR_CTRL;
        cfg_wdata_o = {baud_div_i, 13'd0, 3'b111};
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        if (rx_int_i || err_int_i) w_next = S_RD1;
      end
      S_RD1: begin
        cfg_cs_o   = 1'b1;
        cfg_addr_o = ADDR_RX_DATA;
        w_next     = S_RD2;
      end
      S_RD2: begin
        cfg_cs_o   = 1'b1;
        cfg_addr_o = ADDR_RX_DATA;
        w_next     = S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
    if (!enable_i) w_next = S_IDLE;
  end

  // Error interrupt wins when both fire: the frame is tagged and its byte dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_tag <= 1'b0;
    end else if (r_state == S_WAIT && (rx_int_i || err_int_i)) begin
      r_err_tag <= err_int_i;
    end
  end

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd_done  = (r_state == S_RD2) && enable_i;
  assign w_push_req = w_rd_done && !r_err_tag;
  assign w_pop      = !w_empty && ready_i;
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push && enable_i) begin
      r_mem[r_wr_ptr[AW-1:0]] <= cfg_rdata_i[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else if (!enable_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign valid_o = !w_empty;
  assign data_o  = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign busy_o  = (r_state != S_IDLE);
  assign ovf_o   = r_ovf;

`ifdef UART_RX_CTRL_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= 8'h00;
    end else if (!enable_i) begin
      r_err_cnt <= 8'h00;
    end else if (w_rd_done && r_err_tag && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed and randomized checks of uart_rx_ctrl against a queue model
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_i = 1'b0;
  logic [15:0] baud_div_i = 16'h0000;
  logic        cfg_we_o;
  logic        cfg_cs_o;
  logic [4:0]  cfg_addr_o;
  logic [31:0] cfg_wdata_o;
  logic [31:0] cfg_rdata_i = 32'h0;
  logic        rx_int_i = 1'b0;
  logic        err_int_i = 1'b0;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        busy_o;
  logic        ovf_o;
  logic [7:0]  err_cnt_o;

  int total = 0;
  int bad = 0;

  uart_rx_ctrl #(
    .ADDR_CTRL    (5'h00),
    .ADDR_RX_DATA (5'h03),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable_i),
    .baud_div_i  (baud_div_i),
    .cfg_we_o    (cfg_we_o),
    .cfg_cs_o    (cfg_cs_o),
    .cfg_addr_o  (cfg_addr_o),
    .cfg_wdata_o (cfg_wdata_o),
    .cfg_rdata_i (cfg_rdata_i),
    .rx_int_i    (rx_int_i),
    .err_int_i   (err_int_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .ovf_o       (ovf_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: bus activity as "configuring" or "read cycles left",
  // received bytes as a bounded queue.
  bit        m_active = 1'b0;
  bit        m_cfg = 1'b0;
  int        m_rd_left = 0;
  bit        m_tag = 1'b0;
  bit        m_ovf = 1'b0;
  int        m_err = 0;
  bit        m_pop;
  logic [7:0] q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0; m_cfg = 1'b0; m_rd_left = 0; m_tag = 1'b0;
      m_ovf = 1'b0; m_err = 0; q.delete();
    end else if (!enable_i) begin
      m_active = 1'b0; m_cfg = 1'b0; m_rd_left = 0;
      m_ovf = 1'b0; m_err = 0; q.delete();
    end else begin
      m_pop = (q.size() > 0) && ready_i;
      if (m_pop) void'(q.pop_front());
      if (!m_active) begin
        m_active = 1'b1;
        m_cfg = 1'b1;
      end else if (m_cfg) begin
        m_cfg = 1'b0;
      end else if (m_rd_left == 2) begin
        m_rd_left = 1;
      end else if (m_rd_left == 1) begin
        m_rd_left = 0;
        if (m_tag) begin
          if (m_err < 255) m_err++;
        end else if (q.size() < DEPTH) begin
          q.push_back(cfg_rdata_i[7:0]);
        end else begin
          m_ovf = 1'b1;
        end
      end else if (rx_int_i || err_int_i) begin
        m_rd_left = 2;
        m_tag = err_int_i;
      end
    end
  end

  function automatic logic [7:0] exp_err();
`ifdef UART_RX_CTRL_ERR_CNT_EN
    return 8'(m_err);
`else
    return 8'h00;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("cs",    32'(cfg_cs_o),    32'(m_cfg || m_rd_left > 0));
      chk("we",    32'(cfg_we_o),    32'(m_cfg));
      chk("addr",  32'(cfg_addr_o),  m_cfg ? 32'h0 : (m_rd_left > 0 ? 32'h3 : 32'h0));
      chk("wdata", cfg_wdata_o,      m_cfg ? {baud_div_i, 16'h0007} : 32'h0);
      chk("busy",  32'(busy_o),      32'(m_active));
      chk("valid", 32'(valid_o),     32'(q.size() > 0));
      chk("data",  32'(data_o),      q.size() > 0 ? 32'(q[0]) : 32'h0);
      chk("ovf",   32'(ovf_o),       32'(m_ovf));
      chk("errcnt", 32'(err_cnt_o),  32'(exp_err()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] b, input bit e, input bit r);
    rx_int_i = r;
    err_int_i = e;
    cfg_rdata_i = {24'h0, b};
    cyc();
    rx_int_i = 1'b0;
    err_int_i = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cs"},    32'(cfg_cs_o), 32'h0);
    chk({tag, "_we"},    32'(cfg_we_o), 32'h0);
    chk({tag, "_addr"},  32'(cfg_addr_o), 32'h0);
    chk({tag, "_wdata"}, cfg_wdata_o, 32'h0);
    chk({tag, "_busy"},  32'(busy_o), 32'h0);
    chk({tag, "_valid"}, 32'(valid_o), 32'h0);
    chk({tag, "_data"},  32'(data_o), 32'h0);
    chk({tag, "_ovf"},   32'(ovf_o), 32'h0);
    chk({tag, "_err"},   32'(err_cnt_o), 32'h0);
  endtask

  initial begin
    #2;
    chk_all_zero("reset");

    // Configuration write with baud 10416
    rst = 1'b1;
    enable_i = 1'b1;
    baud_div_i = 16'd10416;
    cyc();
    chk("cfg_cs", 32'(cfg_cs_o), 32'h1);
    chk("cfg_we", 32'(cfg_we_o), 32'h1);
    chk("cfg_addr", 32'(cfg_addr_o), 32'h0);
    chk("cfg_wdata", cfg_wdata_o, 32'h28B0_0007);
    cyc();
    chk("wait_cs", 32'(cfg_cs_o), 32'h0);
    chk("wait_wdata", cfg_wdata_o, 32'h0);
    chk("wait_busy", 32'(busy_o), 32'h1);

    // Single good frame with two-cycle read
    ready_i = 1'b1;
    rx_int_i = 1'b1;
    cfg_rdata_i = 32'h0000_00A5;
    cyc();
    rx_int_i = 1'b0;
    chk("rd1_cs", 32'(cfg_cs_o), 32'h1);
    chk("rd1_we", 32'(cfg_we_o), 32'h0);
    chk("rd1_addr", 32'(cfg_addr_o), 32'h3);
    cyc();
    chk("rd2_addr", 32'(cfg_addr_o), 32'h3);
    chk("rd2_valid", 32'(valid_o), 32'h0);
    cyc();
    chk("a5_valid", 32'(valid_o), 32'h1);
    chk("a5_data", 32'(data_o), 32'hA5);
    chk("a5_cs", 32'(cfg_cs_o), 32'h0);
    cyc();
    chk("a5_popped", 32'(valid_o), 32'h0);

    // Overflow: five frames into a four-deep FIFO
    ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) frame(8'(i), 1'b0, 1'b1);
    chk("ovf_set", 32'(ovf_o), 32'h1);
    ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", 32'(valid_o), 32'h1);
      chk("drain_data", 32'(data_o), 32'(i));
      cyc();
    end
    chk("drain_empty", 32'(valid_o), 32'h0);
    chk("ovf_sticky", 32'(ovf_o), 32'h1);

    // Error interrupt takes priority over rx interrupt
    ready_i = 1'b0;
    frame(8'h3C, 1'b1, 1'b1);
    chk("err_novalid", 32'(valid_o), 32'h0);
`ifdef UART_RX_CTRL_ERR_CNT_EN
    chk("err_cnt1", 32'(err_cnt_o), 32'h1);
`else
    chk("err_cnt1", 32'(err_cnt_o), 32'h0);
`endif

    // Disable during RD1 with two bytes queued
    frame(8'h11, 1'b0, 1'b1);
    frame(8'h22, 1'b0, 1'b1);
    chk("two_queued", 32'(valid_o), 32'h1);
    rx_int_i = 1'b1;
    cfg_rdata_i = 32'h33;
    cyc();
    rx_int_i = 1'b0;
    enable_i = 1'b0;
    cyc();
    chk_all_zero("abort");
    cyc();
    chk("abort_nopush", 32'(valid_o), 32'h0);

    // Error counter saturation
    enable_i = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < 258; i++) frame(8'(i), 1'b1, 1'b0);
`ifdef UART_RX_CTRL_ERR_CNT_EN
    chk("err_sat", 32'(err_cnt_o), 32'hFF);
`else
    chk("err_sat", 32'(err_cnt_o), 32'h0);
`endif
    chk("err_sat_valid", 32'(valid_o), 32'h0);

    // Asynchronous reset mid-WAIT, then CFG on the first edge
    frame(8'h77, 1'b0, 1'b1);
    #1 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    #1 rst = 1'b1;
    cyc();
    chk("rst_cfg_cs", 32'(cfg_cs_o), 32'h1);
    chk("rst_cfg_we", 32'(cfg_we_o), 32'h1);
    cyc();

    // Reset mid-read discards the byte
    rx_int_i = 1'b1;
    cfg_rdata_i = 32'h5A;
    cyc();
    rx_int_i = 1'b0;
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("rst_read_nopush", 32'(valid_o), 32'h0);

    // Randomized traffic checked by the per-cycle compare process
    for (int i = 0; i < 4000; i++) begin
      cyc();
      enable_i = ($urandom_range(0, 59) != 0);
      rx_int_i = ($urandom_range(0, 3) == 0);
      err_int_i = ($urandom_range(0, 7) == 0);
      ready_i = ($urandom_range(0, 2) == 0);
      cfg_rdata_i = $urandom;
      if ($urandom_range(0, 99) == 0) baud_div_i = 16'($urandom);
    end
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter ADDR_CTRL, default 5'h00, uart_top control/baud register address.
REQ-002 SHALL have parameter ADDR_RX_DATA, default 5'h03, uart_top RX data register address.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, received-byte FIFO depth (power of two, 2..16).
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port enable_i  input  1  level: 1 = configure uart_top and receive, 0 = stop.
REQ-007 SHALL have port baud_div_i  input  16  baud divisor written into CTRL[31:16].
REQ-008 SHALL have ports cfg_we_o / cfg_cs_o  output  1 each  uart_top config write enable / chip select.
REQ-009 SHALL have ports cfg_addr_o  output  5  and  cfg_wdata_o  output  32  config address / write data.
REQ-010 SHALL have port cfg_rdata_i  input  32  uart_top config read data.
REQ-011 SHALL have ports rx_int_i / err_int_i  input  1 each  uart_top frame-received / CRC-error interrupts.
REQ-012 SHALL have ports data_o  output  8,  valid_o  output  1,  ready_i  input  1  received-byte stream.
REQ-013 SHALL have ports busy_o  output  1 (FSM not IDLE),  ovf_o  output  1 (sticky FIFO overflow),  err_cnt_o  output  8.

Function
REQ-014 SHALL implement FSM states IDLE, CFG, WAIT, RD1, RD2, with one state per cycle except WAIT.
REQ-015 IDLE -> CFG when enable_i=1; CFG SHALL drive cs=1, we=1, addr=ADDR_CTRL, wdata={baud_div_i,13'd0,3'b111} for exactly one cycle, then -> WAIT.
REQ-016 WAIT SHALL hold cs=0, we=0; on rx_int_i=1 or err_int_i=1 -> RD1; err_int_i takes priority when both high (frame tagged erroneous).
REQ-017 RD1 and RD2 SHALL drive cs=1, we=0, addr=ADDR_RX_DATA; cfg_rdata_i[7:0] SHALL be sampled at the end of RD2 (2-cycle read latency), then -> WAIT.
REQ-018 A good frame's byte SHALL be pushed into the FIFO at the RD2 sample edge; an erroneous frame's byte SHALL be discarded.
REQ-019 Outside CFG/RD1/RD2, cfg_cs_o, cfg_we_o SHALL be 0 and cfg_addr_o, cfg_wdata_o SHALL be 0.
REQ-020 valid_o SHALL be 1 whenever the FIFO is non-empty; data_o SHALL show the head entry; pop on valid_o & ready_i.
REQ-021 Push on full FIFO with no simultaneous pop SHALL drop the byte and set ovf_o; ovf_o clears only by reset or enable_i 1->0.
REQ-022 Simultaneous push and pop on full FIFO SHALL succeed (no drop); on empty FIFO push SHALL appear on valid_o the next cycle (no bypass).
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy tracked with one extra bit.
REQ-024 enable_i=0 in any state SHALL return FSM to IDLE next cycle, abort any read in progress (no push), and flush FIFO.
REQ-025 baud_div_i change while enabled SHALL have no effect until the next IDLE->CFG pass.

Reset
REQ-026 On rst=0, FSM SHALL go to IDLE asynchronously; all outputs 0; FIFO empty; ovf_o=0; err_cnt_o=0.
REQ-027 Reset asserted mid-read SHALL discard the byte; after deassertion with enable_i=1, CFG SHALL occur on the first clk edge.

Configuration
REQ-028 Macro UART_RX_CTRL_ERR_CNT_EN defined: err_cnt_o SHALL increment by 1 per erroneous frame at the RD2 edge, saturating at 255, cleared by reset or enable_i 1->0.
REQ-029 Macro UART_RX_CTRL_ERR_CNT_EN undefined: err_cnt_o SHALL be constant 0, no counter register; erroneous frames still read and discarded.

Verification
REQ-030 enable_i=1, baud_div_i=16'd10416 -> one cycle cs=1, we=1, addr=0, wdata=32'h28B00007, then bus idle.
REQ-031 rx_int_i pulse, cfg_rdata_i=32'hA5, ready_i=1 -> two read cycles at addr 3, valid_o=1 with data_o=8'hA5 the cycle after RD2.
REQ-032 Five good frames 01..05 with ready_i=0, FIFO_DEPTH=4 -> bytes 01..04 held, 05 dropped, ovf_o=1; releasing ready_i yields 01,02,03,04 in order.
REQ-033 err_int_i and rx_int_i high together, rdata=8'h3C -> no push, valid_o stays 0, err_cnt_o=1 (macro defined) / 0 (undefined).
REQ-034 256+2 erroneous frames with macro defined -> err_cnt_o saturates at 8'hFF.
REQ-035 enable_i dropped during RD1 with 2 bytes queued -> IDLE next cycle, no push, valid_o=0, ovf_o=0; rst=0 mid-WAIT -> all outputs 0 immediately, no clk edge needed.
